// File: rtl/audio_serial_rx.sv
// audio_serial_rx: I2S / left-justified / TDM serial audio receiver with sample FIFO.
// Define AUDIO_RX_SYNC_EN to add two-flop synchronisers on bck, lrck and din.
module audio_serial_rx #(
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4,
    localparam int CW      = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                bck,
    input  logic                lrck,
    input  logic                din,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic [CW-1:0]       sample_ch,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overflow,
    input  logic                overflow_clr,
    output logic                frame_err
);

    localparam int TOTAL = CHANNELS * SLOT_W;
    localparam int FW    = $clog2(TOTAL + 1);
    localparam int SW    = $clog2(SLOT_W);
    localparam int AW    = $clog2(DEPTH);
    localparam int EW    = CW + SAMPLE_W;

    typedef enum logic [1:0] {UNLOCKED, SKIP, SHIFT, PAD} state_t;

    logic [2:0] raw;
    logic [2:0] sync_out;
    logic [2:0] in_r;
    logic       bck_d;

    assign raw = {bck, lrck, din};

`ifdef AUDIO_RX_SYNC_EN
    logic [2:0] sync1;
    logic [2:0] sync2;

    // two-flop synchroniser for the asynchronous serial pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end
    assign sync_out = sync2;
`else
    assign sync_out = raw;
`endif

    // input register plus delayed bck for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_r  <= '0;
            bck_d <= 1'b0;
        end else begin
            in_r  <= sync_out;
            bck_d <= in_r[2];
        end
    end

    logic ev, l_v, d_v;
    assign ev  = in_r[2] & ~bck_d;
    assign l_v = in_r[1];
    assign d_v = in_r[0];

    state_t              state;
    logic [FW-1:0]       fcnt;
    logic [SW-1:0]       scnt;
    logic [CW-1:0]       ch;
    logic [SAMPLE_W-1:0] sh;
    logic                lrck_p;
    logic                prev_vld;
    logic                push_q;
    logic [EW-1:0]       push_word;

    logic                fall, rise, start, opp;
    logic [SAMPLE_W-1:0] shifted;

    assign fall    = prev_vld & lrck_p & ~l_v;
    assign rise    = prev_vld & ~lrck_p & l_v;
    assign start   = mode ? rise : fall;
    assign opp     = mode ? fall : rise;
    assign shifted = {sh[SAMPLE_W-2:0], d_v};

    // frame tracker: fcnt is the index of the current bit within the frame,
    // the frame-edge bit being index 0; SKIP means the I2S edge bit was dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= UNLOCKED;
            fcnt      <= '0;
            scnt      <= '0;
            ch        <= '0;
            sh        <= '0;
            lrck_p    <= 1'b0;
            prev_vld  <= 1'b0;
            push_q    <= 1'b0;
            push_word <= '0;
            frame_err <= 1'b0;
        end else begin
            push_q    <= 1'b0;
            frame_err <= 1'b0;
            if (ev) begin
                lrck_p   <= l_v;
                prev_vld <= 1'b1;
                fcnt     <= fcnt + FW'(1);
                if (start) begin
                    if (state != UNLOCKED && fcnt != FW'(TOTAL))
                        frame_err <= 1'b1;
                    fcnt <= FW'(1);
                    ch   <= '0;
                    if (mode) begin
                        state <= SHIFT;
                        sh    <= shifted;
                        scnt  <= SW'(1);
                    end else begin
                        state <= SKIP;
                        scnt  <= '0;
                    end
                end else if (state != UNLOCKED && fcnt == FW'(TOTAL)) begin
                    frame_err <= 1'b1;
                    state     <= UNLOCKED;
                end else begin
                    if (CHANNELS == 2 && opp && state != UNLOCKED &&
                        fcnt != FW'(SLOT_W))
                        frame_err <= 1'b1;
                    unique case (state)
                        UNLOCKED: ;
                        SKIP, SHIFT: begin
                            sh    <= shifted;
                            scnt  <= scnt + SW'(1);
                            state <= SHIFT;
                            if (scnt == SW'(SAMPLE_W - 1)) begin
                                push_q    <= 1'b1;
                                push_word <= {ch, shifted};
                                if (SLOT_W > SAMPLE_W) begin
                                    state <= PAD;
                                end else begin
                                    scnt <= '0;
                                    if (ch != CW'(CHANNELS - 1))
                                        ch <= ch + CW'(1);
                                    else
                                        state <= PAD;
                                end
                            end
                        end
                        PAD: begin
                            scnt <= scnt + SW'(1);
                            if (scnt == SW'(SLOT_W - 1)) begin
                                scnt <= '0;
                                if (ch != CW'(CHANNELS - 1)) begin
                                    ch    <= ch + CW'(1);
                                    state <= SHIFT;
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wp, rp;
    logic          full, pop, wr;

    assign full         = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign sample_valid = (wp != rp);
    assign pop          = sample_valid & sample_ready;
    assign wr           = push_q & (~full | pop);

    assign {sample_ch, sample_data} = mem[rp[AW-1:0]];

    // output FIFO with sticky overflow; a pop frees room for a same-cycle push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wp[AW-1:0]] <= push_word;
                wp              <= wp + (AW+1)'(1);
            end
            if (pop)
                rp <= rp + (AW+1)'(1);
            if (push_q && full && !pop)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end

endmodule
